// File: rtl/match_encoder_8_3.sv
`default_nettype none
// ============================================================================
// Module   : match_encoder_8_3
// Purpose  : Sequential 8-to-3 match-line encoder. Takes an 8-bit row-flag
//            vector and streams the 3-bit index of every set bit, lowest
//            index first, one index per valid/ready handshake.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            vec_valid_i   - row-flag vector presented
//            vec_in_i[7:0] - row flags, bit i = row i asserted
//            vec_ready_o   - vector can be accepted (IDLE only)
//            idx_valid_o   - idx_out_o / idx_last_o are valid
//            idx_out_o[2:0]- index of lowest remaining set bit
//            idx_last_o    - idx_out_o is the final set bit of the vector
//            idx_ready_i   - consumer accepts the current index
//            none_found_o  - one-cycle pulse: accepted vector was all zero
//            busy_o        - high while emitting indices
// Revision : 1.0 - initial release
// ============================================================================
module match_encoder_8_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vec_valid_i,
    input  logic [7:0] vec_in_i,
    output logic       vec_ready_o,
    output logic       idx_valid_o,
    output logic [2:0] idx_out_o,
    output logic       idx_last_o,
    input  logic       idx_ready_i,
    output logic       none_found_o,
    output logic       busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       none_found_q, none_found_d;

    // Clearing the lowest set bit: x & (x-1). When the result is zero the
    // current bit was the only one left, which is exactly the "last" case.
    logic [7:0] pending_clr;
    logic       single_bit;
    logic [2:0] lowest_idx;

    assign pending_clr = pending_q & (pending_q - 8'd1);
    assign single_bit  = (pending_q != 8'd0) && (pending_clr == 8'd0);

    // Priority encoder toward bit 0: scan downward so the lowest hit wins.
    always_comb begin
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= 8'd0;
            none_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            none_found_q <= none_found_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        none_found_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vec_valid_i) begin
                    if (vec_in_i != 8'd0) begin
                        pending_d = vec_in_i;
                        state_d   = ST_EMIT;
                    end else begin
                        none_found_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                // Incoming vectors are ignored here; upstream holds them.
                if (idx_ready_i) begin
                    pending_d = pending_clr;
                    if (single_bit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 8'd0;
            end
        endcase
    end

    // Output logic; index outputs are gated to zero outside EMIT.
    always_comb begin
        vec_ready_o  = 1'b0;
        idx_valid_o  = 1'b0;
        idx_out_o    = 3'd0;
        idx_last_o   = 1'b0;
        busy_o       = 1'b0;
        none_found_o = none_found_q;
        case (state_q)
            ST_IDLE: begin
                vec_ready_o = 1'b1;
            end
            ST_EMIT: begin
                idx_valid_o = 1'b1;
                busy_o      = 1'b1;
                idx_out_o   = lowest_idx;
                idx_last_o  = single_bit;
            end
            default: begin
                vec_ready_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_match_encoder_8_3.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_encoder_8_3
// Purpose  : Self-checking bench for match_encoder_8_3. A behavioural model
//            keeps the outstanding indices of the current vector in a queue
//            and predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_encoder_8_3;

    logic       clk;
    logic       rst_n;
    logic       vec_valid_i;
    logic [7:0] vec_in_i;
    logic       vec_ready_o;
    logic       idx_valid_o;
    logic [2:0] idx_out_o;
    logic       idx_last_o;
    logic       idx_ready_i;
    logic       none_found_o;
    logic       busy_o;

    int n_tests;
    int n_fail;

    // Reference model state
    bit       m_emit;
    int       m_q[$];
    bit       m_nf;

    match_encoder_8_3 u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vec_valid_i  (vec_valid_i),
        .vec_in_i     (vec_in_i),
        .vec_ready_o  (vec_ready_o),
        .idx_valid_o  (idx_valid_o),
        .idx_out_o    (idx_out_o),
        .idx_last_o   (idx_last_o),
        .idx_ready_i  (idx_ready_i),
        .none_found_o (none_found_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_emit = 1'b0;
        m_q.delete();
        m_nf   = 1'b0;
    endtask

    task automatic check_outputs();
        check("vec_ready",  {7'd0, vec_ready_o},  {7'd0, !m_emit});
        check("idx_valid",  {7'd0, idx_valid_o},  {7'd0, m_emit});
        check("busy",       {7'd0, busy_o},       {7'd0, m_emit});
        check("idx_out",    {5'd0, idx_out_o},    m_emit ? 8'(m_q[0]) : 8'd0);
        check("idx_last",   {7'd0, idx_last_o},   {7'd0, (m_emit && m_q.size() == 1)});
        check("none_found", {7'd0, none_found_o}, {7'd0, m_nf});
    endtask

    // One clock cycle: drive at negedge, check, then advance the model to
    // what the next rising edge should produce.
    task automatic cycle(input bit vv, input logic [7:0] vi, input bit ir);
        @(negedge clk);
        vec_valid_i = vv;
        vec_in_i    = vi;
        idx_ready_i = ir;
        #1;
        check_outputs();
        m_nf = 1'b0;
        if (!m_emit) begin
            if (vv) begin
                if (vi == 8'd0) begin
                    m_nf = 1'b1;
                end else begin
                    for (int b = 0; b < 8; b++) begin
                        if (vi[b]) m_q.push_back(b);
                    end
                    m_emit = 1'b1;
                end
            end
        end else if (ir) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_emit = 1'b0;
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        vec_valid_i = 1'b0;
        vec_in_i    = 8'd0;
        idx_ready_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Full vector, no backpressure
        cycle(1'b1, 8'hFF, 1'b1);
        repeat (9) cycle(1'b0, 8'h00, 1'b1);

        // Sparse vector, toggling backpressure
        cycle(1'b1, 8'b1001_0010, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, i[0]);

        // Zero vector
        cycle(1'b1, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);

        // Single bit
        cycle(1'b1, 8'h80, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // Ignored input during EMIT, then accepted in IDLE
        cycle(1'b1, 8'h03, 1'b1);
        repeat (8) cycle(1'b1, 8'hF0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-EMIT
        cycle(1'b1, 8'b1010_0000, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            cycle(($urandom_range(0, 1) == 1), v, ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_encoder_8_3.md
# match_encoder_8_3

Sequential 8-to-3 match-line encoder for the in-memory compute array. It accepts an 8-bit row-flag vector (one bit per SRAM row, e.g. compare/match hits) and emits the 3-bit index of every set bit, lowest index first, one per handshake on a valid/ready stream. It is the reverse path to the row-select decoder: the decoder turns an address into a one-hot word line, and this block turns asserted row lines back into addresses for the controller.

## Interface
- Parameters: none. The width is fixed at 8 rows and a 3-bit index.
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- vec_valid  in  1  a new row-flag vector is presented
- vec_in  in  8  row flags; bit i = row i asserted
- vec_ready  out  1  block can accept a vector (high only in IDLE)
- idx_valid  out  1  idx_out/idx_last hold a valid index
- idx_out  out  3  index of the lowest remaining set bit
- idx_last  out  1  idx_out is the final set bit of the current vector
- idx_ready  in  1  consumer accepts the current index
- none_found  out  1  one-cycle pulse: the accepted vector was all zero
- busy  out  1  high in EMIT

## Operation
- Registered state: `state` {IDLE, EMIT}, `pending` [7:0], `none_found` flop.
- IDLE:
  - vec_ready=1.
  - On vec_valid&vec_ready with vec_in!=0: pending<=vec_in, go to EMIT.
  - On vec_valid&vec_ready with vec_in==0: none_found<=1 for exactly the next cycle, stay in IDLE, pending stays 0.
- EMIT:
  - vec_ready=0. vec_valid and vec_in are ignored and not queued.
  - idx_valid=1, busy=1.
  - idx_out = position of the lowest set bit of pending (priority toward bit 0).
  - idx_last = 1 when pending has exactly one bit set.
  - On idx_valid&idx_ready: clear that bit in pending. If idx_last, go to IDLE; otherwise stay in EMIT and present the next index.
- idx_out and idx_last are combinational from `pending`. They are forced to 0 when idx_valid=0.
- Set bits are never skipped or duplicated. The number of index transfers equals popcount(vec_in).

## Timing
- Reset values (asserted asynchronously, held while rst_n=0):
  - state=IDLE, pending=0
  - vec_ready=1, idx_valid=0, idx_out=0, idx_last=0, none_found=0, busy=0
- Reset deassertion is synchronized externally. The block needs no recovery cycles.
- Latency:
  - Vector accepted at edge T gives idx_valid=1 from T until the first index transfer, i.e. visible in the cycle after T.
  - none_found is high for the single cycle after the accepting edge.
- Throughput:
  - One index per cycle while idx_ready=1.
  - A vector with k set bits occupies EMIT for k cycles minimum.
  - A new vector can be accepted in the cycle after the last transfer (one dead cycle between vectors).
- Backpressure: while idx_valid=1 and idx_ready=0, idx_out, idx_last and pending hold stable.
- idx_ready asserted while idx_valid=0 has no effect.
- Reset mid-EMIT: the remaining pending bits are discarded and idx_valid drops immediately (asynchronously).
- Back-to-back vectors: vec_valid held high across EMIT is accepted only once the block returns to IDLE. The upstream must hold vec_in stable until vec_ready.

## Test plan
- Reset: assert rst_n=0 mid-cycle during EMIT with pending=8'b1010_0000 -> idx_valid=0 at once, vec_ready=1, idx_out=0, and no further indices after release.
- Full vector: vec_in=8'hFF, idx_ready=1 constantly -> idx_out 0,1,...,7 on 8 consecutive cycles, idx_last=1 only with idx_out=7, vec_ready=1 the cycle after.
- Sparse vector with backpressure: vec_in=8'b1001_0010, idx_ready toggling 0/1 -> idx_out 1,4,7 in order, each held stable while idx_ready=0, idx_last=1 only on 7.
- Zero vector: vec_in=8'h00 accepted -> none_found=1 for exactly one cycle, idx_valid never rises, state stays IDLE.
- Single bit: vec_in=8'h80 -> one transfer with idx_out=7 and idx_last=1, busy high for exactly one cycle when idx_ready=1.
- Ignored input: during EMIT of 8'h03, drive vec_valid=1 with vec_in=8'hF0 -> vec_ready=0. Outputs are 0,1, then 8'hF0 is accepted in IDLE, yielding 4,5,6,7.
